// File: rtl/command_line_buffer.sv
// command_line_buffer
//
// Line editor between the PS/2 ASCII decoder and the command logic. Bytes
// qualified by char_valid are assembled into a line of up to MAX_CHARS
// characters with backspace editing. A carriage return commits the line as a
// left-justified packed word (first-typed character in the top byte) with a
// length and a one-cycle cmd_valid pulse. Typing past capacity enters an
// overflow state; the next CR discards the line and pulses cmd_error.
//
// Handshake: char_valid is a single-cycle strobe with no ready/back-pressure.
// A byte is consumed on the rising edge that samples char_valid high. A byte
// arriving while the commit cycle is in progress is dropped; upstream strobes
// are at least two cycles apart, so this cannot happen in normal operation.
//
// Optional feature: define CMD_LINE_UPCASE_EN to fold 'a'..'z' to 'A'..'Z'
// before storage. Without it, bytes are stored verbatim.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   clear      synchronous line discard (committed outputs untouched)
//   char_in    ASCII byte
//   char_valid strobe qualifying char_in
//   line_out   live buffer, slot 0 in bits [8*MAX_CHARS-1 -: 8]
//   line_len   characters currently buffered
//   cmd_out    last committed line, packed like line_out
//   cmd_len    length of cmd_out
//   cmd_valid  one-cycle pulse: new cmd_out/cmd_len
//   cmd_error  one-cycle pulse: overflowed line discarded on CR
//   overflow   high while in the overflow state
//   fsm_state  debug view of the FSM state (0 EDIT, 1 COMMIT, 2 OVF)

module command_line_buffer #(
  parameter int          MAX_CHARS = 5,
  parameter logic [7:0]  PAD_CHAR  = 8'h00,
  localparam int         LW        = $clog2(MAX_CHARS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic [8*MAX_CHARS-1:0] line_out,
  output logic [LW-1:0]          line_len,
  output logic [8*MAX_CHARS-1:0] cmd_out,
  output logic [LW-1:0]          cmd_len,
  output logic                   cmd_valid,
  output logic                   cmd_error,
  output logic                   overflow,
  output logic [1:0]             fsm_state
);

  typedef enum logic [1:0] {
    ST_EDIT   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_OVF    = 2'd2
  } state_t;

  localparam logic [LW-1:0]          MAX_LEN  = LW'(MAX_CHARS);
  localparam logic [8*MAX_CHARS-1:0] PAD_LINE = {MAX_CHARS{PAD_CHAR}};

  state_t state;

  logic                   is_bs;
  logic                   is_cr;
  logic                   is_print;
  logic [7:0]             store_char;
  logic [LW-1:0]          wr_slot;
  logic [7:0]             wr_byte;
  logic [8*MAX_CHARS-1:0] line_wr;

  assign fsm_state = state;

  // Byte classification and optional case folding.
  always_comb begin
    is_bs      = (char_in == 8'h08) || (char_in == 8'h7F);
    is_cr      = (char_in == 8'h0D);
    is_print   = (char_in >= 8'h20) && (char_in <= 8'h7E);
    store_char = char_in;
`ifdef CMD_LINE_UPCASE_EN
    if ((char_in >= 8'h61) && (char_in <= 8'h7A)) begin
      store_char = char_in - 8'h20;
    end
`endif
  end

  // Candidate buffer after a single-slot write: a printable lands in slot
  // line_len, a backspace pads slot line_len-1. Only used when the FSM
  // decides the write is legal.
  always_comb begin
    wr_slot = is_bs ? (line_len - 1'b1) : line_len;
    wr_byte = is_bs ? PAD_CHAR : store_char;
    line_wr = line_out;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (LW'(i) == wr_slot) begin
        line_wr[8*(MAX_CHARS-1-i) +: 8] = wr_byte;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EDIT;
      line_out  <= PAD_LINE;
      line_len  <= '0;
      cmd_out   <= PAD_LINE;
      cmd_len   <= '0;
      cmd_valid <= 1'b0;
      cmd_error <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_error <= 1'b0;
      if (clear) begin
        // Beats everything, including a pending commit.
        state    <= ST_EDIT;
        line_out <= PAD_LINE;
        line_len <= '0;
        overflow <= 1'b0;
      end else begin
        case (state)
          ST_EDIT: begin
            if (char_valid) begin
              if (is_print) begin
                if (line_len < MAX_LEN) begin
                  line_out <= line_wr;
                  line_len <= line_len + 1'b1;
                end else begin
                  state    <= ST_OVF;
                  overflow <= 1'b1;
                end
              end else if (is_bs) begin
                if (line_len != '0) begin
                  line_out <= line_wr;
                  line_len <= line_len - 1'b1;
                end
              end else if (is_cr) begin
                if (line_len != '0) begin
                  state <= ST_COMMIT;
                end
              end
            end
          end
          ST_COMMIT: begin
            // Any char_valid this cycle is intentionally dropped.
            cmd_out   <= line_out;
            cmd_len   <= line_len;
            cmd_valid <= 1'b1;
            line_out  <= PAD_LINE;
            line_len  <= '0;
            state     <= ST_EDIT;
          end
          ST_OVF: begin
            if (char_valid && is_cr) begin
              cmd_error <= 1'b1;
              line_out  <= PAD_LINE;
              line_len  <= '0;
              overflow  <= 1'b0;
              state     <= ST_EDIT;
            end
          end
          default: begin
            state    <= ST_EDIT;
            overflow <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_command_line_buffer.sv
module tb_command_line_buffer;

  localparam int MAX_CHARS = 5;
  localparam int LW        = 3;

  logic                   clk;
  logic                   reset;
  logic                   clear;
  logic [7:0]             char_in;
  logic                   char_valid;
  logic [8*MAX_CHARS-1:0] line_out;
  logic [LW-1:0]          line_len;
  logic [8*MAX_CHARS-1:0] cmd_out;
  logic [LW-1:0]          cmd_len;
  logic                   cmd_valid;
  logic                   cmd_error;
  logic                   overflow;
  logic [1:0]             fsm_state;

  int checks;
  int errors;
  int valid_cnt;
  int error_cnt;
  int v0;
  int e0;

  command_line_buffer #(.MAX_CHARS(MAX_CHARS), .PAD_CHAR(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .char_in    (char_in),
    .char_valid (char_valid),
    .line_out   (line_out),
    .line_len   (line_len),
    .cmd_out    (cmd_out),
    .cmd_len    (cmd_len),
    .cmd_valid  (cmd_valid),
    .cmd_error  (cmd_error),
    .overflow   (overflow),
    .fsm_state  (fsm_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pulse counters, sampled away from the active edge.
  initial begin
    valid_cnt = 0;
    error_cnt = 0;
  end
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) valid_cnt++;
    if (cmd_error === 1'b1) error_cnt++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe followed by one idle cycle; returns #1 after the second edge.
  task automatic send_char(input logic [7:0] b);
    char_in    = b;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    tick();
  endtask

  task automatic type_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (line_out !== 40'h0) begin errors++; $display("FAIL reset_line_out: got %h expected %h", line_out, 40'h0); end
    checks++; if (line_len !== 3'd0) begin errors++; $display("FAIL reset_line_len: got %0d expected 0", line_len); end
    checks++; if (cmd_out !== 40'h0) begin errors++; $display("FAIL reset_cmd_out: got %h expected %h", cmd_out, 40'h0); end
    checks++; if (cmd_len !== 3'd0) begin errors++; $display("FAIL reset_cmd_len: got %0d expected 0", cmd_len); end
    checks++; if ({cmd_valid, cmd_error, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {cmd_valid, cmd_error, overflow}); end
  endtask

  task automatic test_commit();
    v0 = valid_cnt;
    send_char("L");
    checks++; if (line_out !== 40'h4C00000000) begin errors++; $display("FAIL first_char_line: got %h expected %h", line_out, 40'h4C00000000); end
    checks++; if (line_len !== 3'd1) begin errors++; $display("FAIL first_char_len: got %0d expected 1", line_len); end
    type_str("ED");
    checks++; if (line_out !== 40'h4C45440000) begin errors++; $display("FAIL led_line: got %h expected %h", line_out, 40'h4C45440000); end
    // CR strobe: edge N samples it; cmd_valid is up after edge N+1.
    char_in = 8'h0D; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL commit_early_valid: got %b expected 0", cmd_valid); end
    tick();
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL commit_valid: got %b expected 1", cmd_valid); end
    checks++; if (cmd_out !== 40'h4C45440000) begin errors++; $display("FAIL commit_cmd_out: got %h expected %h", cmd_out, 40'h4C45440000); end
    checks++; if (cmd_len !== 3'd3) begin errors++; $display("FAIL commit_cmd_len: got %0d expected 3", cmd_len); end
    checks++; if (line_len !== 3'd0 || line_out !== 40'h0) begin errors++; $display("FAIL commit_line_clear: got len %0d line %h expected 0 0", line_len, line_out); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL commit_pulse_width: got %b expected 0", cmd_valid); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL commit_pulse_count: got %0d expected 1", valid_cnt - v0); end
  endtask

  task automatic test_backspace();
    v0 = valid_cnt;
    type_str("LEX");
    send_char(8'h08);
    checks++; if (line_out !== 40'h4C45000000 || line_len !== 3'd2) begin errors++; $display("FAIL bs_edit: got %h/%0d expected %h/2", line_out, line_len, 40'h4C45000000); end
    send_char("D");
    send_char(8'h0D);
    checks++; if (cmd_out !== 40'h4C45440000 || cmd_len !== 3'd3) begin errors++; $display("FAIL bs_commit: got %h/%0d expected %h/3", cmd_out, cmd_len, 40'h4C45440000); end
    send_char(8'h08);
    send_char(8'h7F);
    checks++; if (line_len !== 3'd0 || line_out !== 40'h0) begin errors++; $display("FAIL bs_empty: got %0d/%h expected 0/0", line_len, line_out); end
    send_char("Q");
    send_char(8'h7F);
    checks++; if (line_len !== 3'd0 || line_out !== 40'h0) begin errors++; $display("FAIL del_7f: got %0d/%h expected 0/0", line_len, line_out); end
    send_char(8'h01);
    send_char(8'h80);
    checks++; if (line_len !== 3'd0) begin errors++; $display("FAIL ignored_bytes: got %0d expected 0", line_len); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL bs_pulse_count: got %0d expected 1", valid_cnt - v0); end
  endtask

  task automatic test_overflow();
    v0 = valid_cnt; e0 = error_cnt;
    type_str("ABCDE");
    checks++; if (line_out !== 40'h4142434445 || line_len !== 3'd5 || overflow !== 1'b0) begin errors++; $display("FAIL full_line: got %h/%0d/%b expected %h/5/0", line_out, line_len, overflow, 40'h4142434445); end
    send_char("F");
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (line_out !== 40'h4142434445 || line_len !== 3'd5) begin errors++; $display("FAIL ovf_buffer_kept: got %h/%0d expected %h/5", line_out, line_len, 40'h4142434445); end
    send_char(8'h08);
    checks++; if (overflow !== 1'b1 || line_len !== 3'd5) begin errors++; $display("FAIL ovf_bs_ignored: got %b/%0d expected 1/5", overflow, line_len); end
    char_in = 8'h0D; char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
    checks++; if (cmd_error !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_cr: got err %b ovf %b expected 1 0", cmd_error, overflow); end
    tick();
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL ovf_err_width: got %b expected 0", cmd_error); end
    checks++; if (error_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin errors++; $display("FAIL ovf_pulses: got err %0d valid %0d expected 1 0", error_cnt - e0, valid_cnt - v0); end
    checks++; if (cmd_out !== 40'h4C45440000 || cmd_len !== 3'd3) begin errors++; $display("FAIL ovf_cmd_kept: got %h/%0d expected %h/3", cmd_out, cmd_len, 40'h4C45440000); end
    checks++; if (line_out !== 40'h0 || line_len !== 3'd0) begin errors++; $display("FAIL ovf_line_clear: got %h/%0d expected 0/0", line_out, line_len); end
  endtask

  task automatic test_clear();
    v0 = valid_cnt; e0 = error_cnt;
    type_str("AB");
    char_in = "C"; char_valid = 1'b1; clear = 1'b1;
    tick();
    char_valid = 1'b0; clear = 1'b0;
    tick();
    checks++; if (line_out !== 40'h0 || line_len !== 3'd0) begin errors++; $display("FAIL clear_line: got %h/%0d expected 0/0", line_out, line_len); end
    send_char(8'h0D);
    tick();
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL clear_no_pulse: got %0d expected 0", valid_cnt - v0); end
    type_str("ABCDEF");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (overflow !== 1'b0 || line_len !== 3'd0) begin errors++; $display("FAIL clear_ovf: got %b/%0d expected 0/0", overflow, line_len); end
    send_char(8'h0D);
    checks++; if (error_cnt - e0 !== 0 || cmd_out !== 40'h4C45440000) begin errors++; $display("FAIL clear_ovf_no_err: got %0d/%h expected 0/%h", error_cnt - e0, cmd_out, 40'h4C45440000); end
  endtask

  task automatic test_back_to_back();
    v0 = valid_cnt;
    // Full-length commit, with a strobe landing in the commit cycle.
    type_str("HELLO");
    char_in = 8'h0D; char_valid = 1'b1;
    tick();
    char_in = "Z";
    tick();
    char_valid = 1'b0;
    checks++; if (cmd_out !== 40'h48454C4C4F || cmd_len !== 3'd5) begin errors++; $display("FAIL full_commit: got %h/%0d expected %h/5", cmd_out, cmd_len, 40'h48454C4C4F); end
    tick();
    checks++; if (line_len !== 3'd0 || line_out !== 40'h0) begin errors++; $display("FAIL commit_drop: got %0d/%h expected 0/0", line_len, line_out); end
    // clear during COMMIT suppresses the pulse.
    type_str("XY");
    char_in = 8'h0D; char_valid = 1'b1;
    tick();
    char_valid = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    checks++; if (valid_cnt - v0 !== 1 || cmd_out !== 40'h48454C4C4F) begin errors++; $display("FAIL clear_in_commit: got %0d/%h expected 1/%h", valid_cnt - v0, cmd_out, 40'h48454C4C4F); end
  endtask

  task automatic test_reset_in_commit();
    v0 = valid_cnt;
    type_str("AB");
    char_in = 8'h0D; char_valid = 1'b1;
    tick();
    char_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL rst_commit_pulse: got %0d expected 0", valid_cnt - v0); end
    checks++; if (cmd_out !== 40'h0 || cmd_len !== 3'd0) begin errors++; $display("FAIL rst_commit_cmd: got %h/%0d expected 0/0", cmd_out, cmd_len); end
    checks++; if (line_out !== 40'h0 || line_len !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_commit_line: got %h/%0d/%b expected 0/0/0", line_out, line_len, overflow); end
  endtask

  task automatic test_upcase();
    logic [39:0] exp_cmd;
`ifdef CMD_LINE_UPCASE_EN
    exp_cmd = 40'h4C45440000;
`else
    exp_cmd = 40'h6C65640000;
`endif
    type_str("led");
    send_char(8'h0D);
    checks++; if (cmd_out !== exp_cmd || cmd_len !== 3'd3) begin errors++; $display("FAIL upcase: got %h/%0d expected %h/3", cmd_out, cmd_len, exp_cmd); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; clear = 1'b0; char_in = 8'h00; char_valid = 1'b0;
    test_reset();
    test_commit();
    test_backspace();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_reset_in_commit();
    test_upcase();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
